// File: rtl/dcache_responder.sv
// Multi-cycle word data-memory responder for the memory-stage dCache port.
// Accepts one load/store at a time and pulses dCacheDone a fixed LATENCY edges after acceptance.
module dcache_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dCacheAddr,
    input  logic        dCacheReadEn,
    input  logic        dCacheWriteEn,
    input  logic [31:0] dCacheWriteData,
    output logic [31:0] dCacheReadData,
    output logic        dCacheDone,
    output logic        dCacheBusy,
    output logic        dCacheErr
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           wdata;
        logic                  is_load;
        logic                  err;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             addr_err_c;
    logic             enter_resp_c;
    logic [31:0]      mem [DEPTH];

    // Illegal if misaligned or beyond the array; out-of-range addresses never alias
    assign addr_err_c = (dCacheAddr[1:0] != 2'b00) ||
                        ((dCacheAddr >> (ADDR_WIDTH + 2)) != 32'd0);

    assign enter_resp_c = (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Counter holds the remaining WAIT edges; RESP is entered LATENCY edges after capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (dCacheReadEn || dCacheWriteEn) begin
                    req_d.idx     = dCacheAddr[ADDR_WIDTH+1:2];
                    req_d.wdata   = dCacheWriteData;
                    req_d.is_load = dCacheReadEn;
                    req_d.err     = addr_err_c || (dCacheReadEn && dCacheWriteEn);
                    cnt_d         = CNT_W'(LATENCY - 1);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (enter_resp_c && !req_q.is_load && !req_q.err) begin
            mem[req_q.idx] <= req_q.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dCacheReadData <= '0;
            dCacheDone     <= 1'b0;
            dCacheBusy     <= 1'b0;
            dCacheErr      <= 1'b0;
        end else begin
            dCacheDone <= enter_resp_c;
            dCacheErr  <= enter_resp_c && req_q.err;
            dCacheBusy <= (state_d != IDLE);
            if (enter_resp_c && req_q.is_load && !req_q.err) begin
                dCacheReadData <= mem[req_q.idx];
            end
        end
    end

endmodule
